// File: rtl/fetch_stage_if.sv
// Instruction bus interface between the fetch stage and the instruction memory system.
//
// Request channel (driven by the fetch stage, the master):
//   ireq_valid    : a request is being presented
//   ireq_addr     : 64-bit fetch address, held stable while ireq_valid until addr_ok
// Response channel (driven by the bus, the slave):
//   iresp_addr_ok : request accepted this cycle
//   iresp_data_ok : instruction data returned this cycle
//   iresp_data    : 32-bit instruction word, qualified by iresp_data_ok
interface fetch_stage_if;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_addr_ok;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  iresp_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output iresp_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end. Owns the PC, issues one request at a time on the
// instruction bus and hands each returned instruction plus its PC to decode over a
// valid/ready handshake. Redirects from execute restart the stream at a new PC; any
// fetch already on the bus when a redirect arrives has its response discarded.
//
// Ports:
//   clk         : core clock, all state on the rising edge
//   reset       : asynchronous active-low reset (0 = in reset)
//   ibus        : instruction bus (master side), see fetch_stage_if
//   redirect    : discard the current stream and restart at redirect_pc
//   redirect_pc : new fetch PC, word aligned
//   out_valid   : instruction/PC pair valid to decode
//   out_ready   : decode accepts the pair when out_valid & out_ready
//   out_pc      : PC of the delivered instruction
//   out_instr   : delivered instruction word
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_stage_if.master        ibus,
  input  logic                 redirect,
  input  logic [63:0]          redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          out_pc,
  output logic [31:0]          out_instr
);

  // REQ : request presented on the bus, waiting for addr_ok
  // WAIT: request accepted, waiting for data_ok
  // HOLD: instruction captured, offered to decode
  localparam logic [1:0] StReq  = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]  state_q,      state_d;
  logic [63:0] pc_q,         pc_d;
  logic        drop_q,       drop_d;
  logic [63:0] pend_pc_q,    pend_pc_d;
  logic [63:0] hold_pc_q,    hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;

  // The request is gated by reset so the bus sees nothing while reset is held,
  // even though the state register already sits in REQ.
  assign ibus.ireq_valid = (state_q == StReq) && reset;
  assign ibus.ireq_addr  = pc_q;

  // A redirect in HOLD cancels the offer in the same cycle, so decode never
  // consumes an instruction from the stream being abandoned.
  assign out_valid = (state_q == StHold) && !redirect;
  assign out_pc    = hold_pc_q;
  assign out_instr = hold_instr_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    pend_pc_d    = pend_pc_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;

    case (state_q)
      StReq: begin
        if (redirect) begin
          // The presented request cannot be withdrawn; let it complete and
          // throw its response away, then restart at the pending PC.
          drop_d    = 1'b1;
          pend_pc_d = redirect_pc;
          if (ibus.iresp_addr_ok) begin
            state_d = StWait;
          end
        end else if (ibus.iresp_addr_ok) begin
          state_d = StWait;
        end
      end

      StWait: begin
        if (redirect) begin
          if (ibus.iresp_data_ok) begin
            // Outstanding response lands now and is discarded; bus is free.
            drop_d  = 1'b0;
            pc_d    = redirect_pc;
            state_d = StReq;
          end else begin
            drop_d    = 1'b1;
            pend_pc_d = redirect_pc;
          end
        end else if (ibus.iresp_data_ok) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            pc_d    = pend_pc_q;
            state_d = StReq;
          end else begin
            hold_pc_d    = pc_q;
            hold_instr_d = ibus.iresp_data;
            state_d      = StHold;
          end
        end
      end

      StHold: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = StReq;
        end else if (out_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = StReq;
        end
      end

      default: begin
        // Unreachable encoding: recover by refetching from the current PC.
        drop_d  = 1'b0;
        state_d = StReq;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StReq;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      pend_pc_q    <= 64'd0;
      hold_pc_q    <= 64'd0;
      hold_instr_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      pend_pc_q    <= pend_pc_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. The stimulus process plays the instruction bus
// and decode, checking bus-side outputs directly; every instruction expected to
// reach decode is pushed into a scoreboard that a separate monitor drains on each
// accepted transfer.
module tb_fetch_stage;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  int unsigned vectors;
  int unsigned miscompares;
  exp_t        sb_q[$];

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (64'h0000_0000_8000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ibus        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge; inputs are changed right after it.
  task automatic step();
    @(negedge clk);
  endtask

  // Entered just after a negedge with the DUT presenting a request at exp_addr.
  // addr_ok on the issue cycle, data_ok on the next; leaves the DUT in HOLD.
  task automatic fetch(input logic [63:0] exp_addr, input logic [31:0] instr,
                       input bit push);
    bus.iresp_addr_ok = 1'b1;
    #1;
    check("issue_valid", {63'd0, bus.ireq_valid}, 64'd1);
    check("issue_addr", bus.ireq_addr, exp_addr);
    step();
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = instr;
    if (push) sb_q.push_back('{pc: exp_addr, instr: instr});
    #1;
    check("wait_no_valid", {63'd0, out_valid}, 64'd0);
    step();
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = 32'd0;
    #1;
    check("hold_valid", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // Scoreboard monitor: samples mid-cycle, after the stimulus has settled.
  always @(negedge clk) begin : monitor
    exp_t e;
    #2;
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_transfer: got pc %h instr %h, expected none", out_pc, out_instr);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", {32'd0, out_instr}, {32'd0, e.instr});
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    vectors           = 0;
    miscompares       = 0;
    reset             = 1'b0;
    redirect          = 1'b0;
    redirect_pc       = 64'd0;
    out_ready         = 1'b0;
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = 32'd0;

    // Reset state
    #1;
    check("rst_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    check("rst_out_instr", {32'd0, out_instr}, 64'd0);

    // 1: first fetch after reset release, minimum latency
    step();
    reset = 1'b1;
    fetch(64'h0000_0000_8000_0000, 32'h0000_0013, 1'b1);

    // 2: decode stalls for 5 cycles, HOLD contents must not move
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_instr", {32'd0, out_instr}, 64'h13);
    end
    step();
    accept();
    #1;
    check("seq_addr", bus.ireq_addr, 64'h0000_0000_8000_0004);

    // 3: redirect while WAIT, stale response must vanish
    bus.iresp_addr_ok = 1'b1;
    #1;
    check("t3_issue_addr", bus.ireq_addr, 64'h0000_0000_8000_0004);
    step();
    bus.iresp_addr_ok = 1'b0;
    redirect          = 1'b1;
    redirect_pc       = 64'h0000_0000_8000_0100;
    step();
    redirect          = 1'b0;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'hDEAD_BEEF;
    #1;
    check("t3_stale_no_valid", {63'd0, out_valid}, 64'd0);
    step();
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = 32'd0;
    fetch(64'h0000_0000_8000_0100, 32'h0000_0093, 1'b1);
    step();
    accept();

    // 4: redirect in REQ with addr_ok stalled; second redirect overrides first
    redirect    = 1'b1;
    redirect_pc = 64'h0000_0000_8000_0180;
    #1;
    check("t4_addr_c1", bus.ireq_addr, 64'h0000_0000_8000_0104);
    step();
    redirect_pc = 64'h0000_0000_8000_0200;
    #1;
    check("t4_addr_c2", bus.ireq_addr, 64'h0000_0000_8000_0104);
    step();
    redirect = 1'b0;
    #1;
    check("t4_addr_c3", bus.ireq_addr, 64'h0000_0000_8000_0104);
    check("t4_valid_c3", {63'd0, bus.ireq_valid}, 64'd1);
    step();
    bus.iresp_addr_ok = 1'b1;
    #1;
    check("t4_addr_ok", bus.ireq_addr, 64'h0000_0000_8000_0104);
    step();
    bus.iresp_addr_ok = 1'b0;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'hBAD0_0001;
    step();
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = 32'd0;
    fetch(64'h0000_0000_8000_0200, 32'h00A0_0113, 1'b1);
    step();
    accept();

    // 5: redirect coincides with out_ready in HOLD
    fetch(64'h0000_0000_8000_0204, 32'h0010_0093, 1'b0);
    step();
    redirect    = 1'b1;
    redirect_pc = 64'h0000_0000_8000_0400;
    out_ready   = 1'b1;
    #1;
    check("t5_cancel_valid", {63'd0, out_valid}, 64'd0);
    step();
    redirect  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("t5_next_addr", bus.ireq_addr, 64'h0000_0000_8000_0400);

    // 6: reset asserted while WAIT, late data_ok after release
    bus.iresp_addr_ok = 1'b1;
    step();
    bus.iresp_addr_ok = 1'b0;
    reset             = 1'b0;
    #1;
    check("t6_rst_ireq_valid", {63'd0, bus.ireq_valid}, 64'd0);
    check("t6_rst_out_valid", {63'd0, out_valid}, 64'd0);
    step();
    reset             = 1'b1;
    bus.iresp_data_ok = 1'b1;
    bus.iresp_data    = 32'hFEED_F00D;
    #1;
    check("t6_restart_addr", bus.ireq_addr, 64'h0000_0000_8000_0000);
    step();
    bus.iresp_data_ok = 1'b0;
    bus.iresp_data    = 32'd0;
    #1;
    check("t6_late_ignored", {63'd0, out_valid}, 64'd0);
    check("t6_still_req", {63'd0, bus.ireq_valid}, 64'd1);
    fetch(64'h0000_0000_8000_0000, 32'h0000_0513, 1'b1);
    step();
    accept();

    step();
    step();
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
